count_display_driver: RTL and testbench
=======================================

Name: count_display_driver

Overview:
Downstream consumer of the 8-bit step counter output.
- Converts the unsigned count into three BCD digits (hundreds, tens, ones) using a sequential shift-and-add-3 (double-dabble) engine.
- Time-multiplexes the three digits onto a common-anode 7-segment display.
- Sits between the counter's count bus and the board display pins; no handshake back to the counter.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot; legal range >= 1; prescaler width = $clog2(SCAN_DIV) or 1 if SCAN_DIV=1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- value  input  8  unsigned count to display; sampled only in IDLE.
- blank  input  1  1 = all anodes off, i.e. an=3'b111; conversion and scan continue.
- busy  output  1  1 while a conversion is in progress.
- bcd  output  12  last completed result {hundreds, tens, ones}, 4 bits each.
- seg  output  8  active-low {dp,g,f,e,d,c,b,a}; dp always 1.
- an  output  3  active-low one-hot digit select; an[0]=ones, an[1]=tens, an[2]=hundreds.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, last_value=0, bcd=12'h000, busy=0, prescaler=0, idx=0. Resulting outputs: an=3'b110, seg=8'hC0 (digit 0).
- Reset overrides everything, including a mid-conversion; a partial result is discarded.
- Conversion FSM states:
  - IDLE: when value != last_value, capture value into shift reg and into last_value, clear the 12-bit scratch, iter=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: each cycle, add 3 to every scratch nibble >= 5, then shift {scratch,shift} left by 1; iter++. After the 8th shift go to DONE.
  - DONE: bcd <= scratch; go to IDLE.
- Latency: capture edge E0, shifts E1..E8, bcd updated at E9, so 9 cycles from capture to new bcd. busy=1 from after E0 through E9 (9 cycles); busy=0 in IDLE.
- value changes while busy are ignored. On return to IDLE, the current value is compared with last_value and re-converted if different. Minimum period between bcd updates is 10 cycles.
- Range: value 0..255 gives bcd 0x000..0x255; the hundreds nibble never exceeds 2.
- Scan prescaler: counts 0..SCAN_DIV-1. On a wrap, idx advances 0→1→2→0; idx never takes value 3.
- an and seg are combinational decodes of registered idx, bcd and blank. They change in the same cycle that idx or bcd changes, with no glitch-sensitive gating.
- seg[6:0] codes (active-low, g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111; nibbles >9 also decode to blank (unreachable, defensive).
- bcd holds the previous result during a conversion, so the display never shows partial scratch.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: the hundreds digit is blank when it is 0. The tens digit is blank when hundreds and tens are both 0. The selected anode stays driven, with seg[6:0]=1111111. Ones is never blanked, so value 0 shows a single "0".
- Undefined: all three digits are always shown, e.g. 007.

Test Plan:
- Reset, then hold value=0 → busy stays 0, bcd=000, an=110, seg=C0; no conversion starts.
- value 0→255 at cycle T → busy=1 for cycles T+1..T+9, bcd=0x255 from T+10; SCAN_DIV=4 frame shows seg 0x92,0x92,0xA4 on an 110,101,011.
- value=100, then change to 37 at busy cycle 3 → bcd=0x100 first; a second conversion starts the cycle after busy falls; final bcd=0x037.
- SCAN_DIV=1 → idx rotates every cycle, an sequence 110,101,011,110. Assert blank=1 → an=111 while idx keeps advancing.
- rst asserted at busy cycle 5 of a conversion of 199 → next cycle busy=0, bcd=000, last_value=0; with value still 199, a new conversion starts one cycle after rst drops and yields 0x199.
- LEADING_ZERO_BLANK_EN defined, value=7 → hundreds and tens slots seg=FF, ones seg=F8; value=0 → ones seg=C0.

Source files
------------

// File: rtl/count_display_driver.sv
// count_display_driver
//   Converts an 8-bit unsigned count to three BCD digits with a sequential
//   shift-and-add-3 engine. It then time-multiplexes the digits onto a
//   common-anode 7-segment display.
//
// Ports
//   clk    in   system clock, all logic on posedge
//   rst    in   synchronous active-high reset
//   value  in   [7:0] count to display; sampled only while idle
//   blank  in   1 = all anodes off; conversion and scan keep running
//   busy   out  high while a conversion is in progress
//   bcd    out  [11:0] last completed result {hundreds, tens, ones}
//   seg    out  [7:0] active-low {dp,g,f,e,d,c,b,a}; dp always 1
//   an     out  [2:0] active-low one-hot digit select (0=ones, 2=hundreds)
//
// Parameters
//   SCAN_DIV  clk cycles per digit slot (>= 1)
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, suppresses leading zeros in the
//                          hundreds and tens digits. Ones is always shown.
module count_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  value,
  input  logic        blank,
  output logic        busy,
  output logic [11:0] bcd,
  output logic [7:0]  seg,
  output logic [2:0]  an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    last_q;
  logic [7:0]    shift_q;
  logic [11:0]   scratch_q;
  logic [2:0]    iter_q;
  logic [11:0]   bcd_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;

  logic          start;
  logic [11:0]   adj;

  assign start = (value != last_q);

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (iter_q == 3'd7) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // Add 3 to every nibble >= 5 before the shift, so the doubling carries
  // correctly into the next decimal digit.
  always_comb begin
    adj = scratch_q;
    for (int n = 0; n < 3; n++) begin
      if (scratch_q[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = scratch_q[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 8'h00;
      shift_q   <= 8'h00;
      scratch_q <= 12'h000;
      iter_q    <= 3'd0;
      bcd_q     <= 12'h000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shift_q   <= value;
            last_q    <= value;
            scratch_q <= 12'h000;
            iter_q    <= 3'd0;
          end
        end
        S_SHIFT: begin
          scratch_q <= {adj[10:0], shift_q[7]};
          shift_q   <= {shift_q[6:0], 1'b0};
          iter_q    <= iter_q + 3'd1;
        end
        S_DONE:  bcd_q <= scratch_q;
        default: ;
      endcase
    end
  end

  assign bcd = bcd_q;

  // ---------------- scan prescaler ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= 2'd0;
    end else if (presc_q == PRESC_MAX) begin
      presc_q <= '0;
      idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // ---------------- display decode ----------------
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic [3:0] digit;
  logic       lz;

  always_comb begin
    digit = 4'd0;
    lz    = 1'b0;
    case (idx_q)
      2'd0:    digit = bcd_q[3:0];
      2'd1:    digit = bcd_q[7:4];
      2'd2:    digit = bcd_q[11:8];
      default: digit = 4'd0;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // Anode stays driven; only the segments go dark for a leading zero.
    if (idx_q == 2'd2 && bcd_q[11:8] == 4'd0) lz = 1'b1;
    if (idx_q == 2'd1 && bcd_q[11:4] == 8'h00) lz = 1'b1;
`else
    lz = 1'b0;
`endif
  end

  always_comb begin
    an = 3'b111;
    if (!blank) begin
      case (idx_q)
        2'd0:    an = 3'b110;
        2'd1:    an = 3'b101;
        2'd2:    an = 3'b011;
        default: an = 3'b111;
      endcase
    end
    seg = {1'b1, lz ? 7'b1111111 : seg7(digit)};
  end

endmodule

// File: tb/tb_count_display_driver.sv
module tb_count_display_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  value;
  logic        blank;
  logic        busy4, busy1;
  logic [11:0] bcd4, bcd1;
  logic [7:0]  seg4, seg1;
  logic [2:0]  an4, an1;

  always #5 clk = ~clk;

  count_display_driver #(.SCAN_DIV(4)) u_dut4 (
    .clk(clk), .rst(rst), .value(value), .blank(blank),
    .busy(busy4), .bcd(bcd4), .seg(seg4), .an(an4)
  );

  count_display_driver #(.SCAN_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .value(value), .blank(blank),
    .busy(busy1), .bcd(bcd1), .seg(seg1), .an(an1)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [11:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // cycles since the last reset edge, used to predict the scan slot
  int   m_cnt = 0;
  logic rst_hit = 1'b0;
  always @(posedge clk) begin
    rst_hit <= rst;
    m_cnt   <= rst ? 0 : m_cnt + 1;
  end

  localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000};

  function automatic logic [10:0] disp(input logic [11:0] b, input int idx, input logic bl);
    logic [3:0] d;
    logic       z;
    logic [2:0] a;
    d = b[idx*4 +: 4];
    z = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx == 2 && b[11:8] == 4'd0) z = 1'b1;
    if (idx == 1 && b[11:4] == 8'h00) z = 1'b1;
`endif
    a = bl ? 3'b111 : ~(3'b001 << idx);
    disp = {a, 1'b1, z ? 7'b1111111 : SEGS[d]};
  endfunction

  task automatic chk_disp(input logic [11:0] b);
    logic [10:0] e4, e1;
    e4 = disp(b, (m_cnt / 4) % 3, blank);
    e1 = disp(b, m_cnt % 3, blank);
    chk("an4", {29'd0, an4}, {29'd0, e4[10:8]});
    chk("seg4", {24'd0, seg4}, {24'd0, e4[7:0]});
    chk("an1", {29'd0, an1}, {29'd0, e1[10:8]});
    chk("seg1", {24'd0, seg1}, {24'd0, e1[7:0]});
  endtask

  // scoreboard consumer: each completed conversion pops one expected bcd
  logic busy_prev = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    if (rst_hit) begin
      busy_prev = 1'b0;
      bcnt = 0;
    end else begin
      if (busy4) bcnt++;
      if (busy_prev && !busy4) begin
        chk("busy_len", bcnt, 9);
        if (sb.size() > 0) begin
          logic [11:0] e;
          e = sb.pop_front();
          chk("bcd4", {20'd0, bcd4}, {20'd0, e});
          chk("bcd1", {20'd0, bcd1}, {20'd0, e});
        end else begin
          chk("sb_empty", sb.size(), 1);
        end
        bcnt = 0;
      end
      busy_prev = busy4;
    end
  end

  function automatic logic [11:0] to_bcd(input int v);
    to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic drive(input int v);
    @(posedge clk); #1;
    value = 8'(v);
    sb.push_back(to_bcd(v));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; value = 8'd0; blank = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_disp(12'h000);
    chk("rst_busy", {31'd0, busy4}, 0);
    @(posedge clk); #1 rst = 1'b0;

    // idle with value==0: no conversion
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy4", {31'd0, busy4}, 0);
      chk("idle_busy1", {31'd0, busy1}, 0);
      chk("idle_bcd", {20'd0, bcd4}, 0);
      chk_disp(12'h000);
    end

    // 0 -> 255, latency and full scan frame
    drive(255);
    @(negedge clk); chk("pre_cap_busy", {31'd0, busy4}, 0);
    @(negedge clk); chk("post_cap_busy", {31'd0, busy4}, 1);
    chk("hold_bcd", {20'd0, bcd4}, 0);
    wait_idle();
    repeat (12) begin @(negedge clk); chk_disp(12'h255); end

    // change during busy: first result then reconversion
    drive(100);
    repeat (3) @(posedge clk);
    #1 value = 8'd37;
    sb.push_back(to_bcd(37));
    wait_idle();
    chk("final37", {20'd0, bcd4}, 32'h037);

    // blank forces anodes off while scan keeps moving
    @(posedge clk); #1 blank = 1'b1;
    repeat (6) begin @(negedge clk); chk_disp(12'h037); end
    @(posedge clk); #1 blank = 1'b0;
    repeat (6) begin @(negedge clk); chk_disp(12'h037); end

    // reset mid-conversion discards it; reconversion follows
    drive(199);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy4}, 0);
    chk("abort_bcd", {20'd0, bcd4}, 0);
    chk_disp(12'h000);
    @(negedge clk);
    chk("restart_busy", {31'd0, busy4}, 1);
    wait_idle();
    chk("final199", {20'd0, bcd4}, 32'h199);

    // small values exercise leading-zero handling
    drive(7);
    wait_idle();
    repeat (12) begin @(negedge clk); chk_disp(12'h007); end
    drive(0);
    wait_idle();
    repeat (12) begin @(negedge clk); chk_disp(12'h000); end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
